// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial subtractor sequencer.
// One full_sub cell is reused WIDTH times, LSB first, to form
// diff = a - b - bin (mod 2^WIDTH) and the final borrow bout.
//
// Handshake (start/done):
//   - start is sampled only while idle (IDLE) or presenting a result (DONE).
//     A sampled start loads the operands on that edge; starts seen during
//     RUN are dropped, never queued.
//   - busy is high for exactly WIDTH cycles per operation (RUN state).
//   - done is a one-cycle pulse (DONE state). diff/bout are valid from
//     done until the next accepted start; busy and done are never both high.
//   - start held high in DONE launches the next operation back-to-back.
// dbg_state exposes the FSM encoding (0=IDLE, 1=RUN, 2=DONE) for observation.

// ---------------------------------------------------------------------------
// full_sub: one-bit full subtractor, i_a - i_b - i_bin.
// ---------------------------------------------------------------------------
module full_sub (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_diff,
  output logic o_bout
);

  logic w_axb;

  // Difference is the XOR of all three bits; borrow when the subtrahend
  // side (b plus incoming borrow) outweighs a.
  always_comb begin
    w_axb  = i_a ^ i_b;
    o_diff = w_axb ^ i_bin;
    o_bout = (~i_a & i_b) | (~w_axb & i_bin);
  end

endmodule

// ---------------------------------------------------------------------------
// serial_sub_ctrl: control FSM, operand shifters and result accumulator.
// ---------------------------------------------------------------------------
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic [1:0]       dbg_state
);

  // Counter just wide enough to index WIDTH bit positions.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // State and datapath registers.
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_brw;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  // Combinational helpers.
  logic [1:0] w_state_nxt;
  logic       w_accept;
  logic       w_last;
  logic       w_fs_diff;
  logic       w_fs_bout;

  // The single shared subtractor cell always looks at the operand LSBs
  // and the running borrow; its outputs only matter while in RUN.
  full_sub u_full_sub (
    .i_a    (r_a_sh[0]),
    .i_b    (r_b_sh[0]),
    .i_bin  (r_brw),
    .o_diff (w_fs_diff),
    .o_bout (w_fs_bout)
  );

  // Decode whether a new request is taken this cycle and whether the
  // current RUN cycle handles the most significant bit.
  always_comb begin
    w_accept = start & ((r_state == S_IDLE) | (r_state == S_DONE));
    w_last   = (r_state == S_RUN) & (r_cnt == CNT_LAST);
  end

  // Next-state logic; the unused encoding falls back to IDLE.
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:  w_state_nxt = w_accept ? S_RUN : S_IDLE;
      S_RUN:   w_state_nxt = w_last ? S_DONE : S_RUN;
      S_DONE:  w_state_nxt = w_accept ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath: load operands on an accepted start, otherwise shift one bit
  // per RUN cycle. Result bits enter at the top so that after WIDTH cycles
  // the LSB computed first has reached bit 0. diff/bout hold outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_brw  <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else if (w_accept) begin
      r_a_sh <= a;
      r_b_sh <= b;
      r_brw  <= bin;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_diff <= {w_fs_diff, r_diff[WIDTH-1:1]};
      r_brw  <= w_fs_bout;
      r_cnt  <= r_cnt + CNT_ONE;
      if (w_last) begin
        r_bout <= w_fs_bout;
      end
    end
  end

  // Outputs decoded straight from state so that reset clears them at once.
  always_comb begin
    busy      = (r_state == S_RUN);
    done      = (r_state == S_DONE);
    diff      = r_diff;
    bout      = r_bout;
    dbg_state = r_state;
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl: an 8-bit instance for latency,
// handshake and reset behaviour, plus a 4-bit instance swept over every
// operand combination against an arithmetic reference.
module tb_serial_sub_ctrl;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 8-bit DUT ----------------
  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;
  logic [1:0] st8;

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start8),
    .a         (a8),
    .b         (b8),
    .bin       (bin8),
    .busy      (busy8),
    .done      (done8),
    .diff      (diff8),
    .bout      (bout8),
    .dbg_state (st8)
  );

  // ---------------- 4-bit DUT ----------------
  logic       start4, bin4, busy4, done4, bout4;
  logic [3:0] a4, b4, diff4;
  logic [1:0] st4;

  serial_sub_ctrl #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start4),
    .a         (a4),
    .b         (b4),
    .bin       (bin4),
    .busy      (busy4),
    .done      (done4),
    .diff      (diff4),
    .bout      (bout4),
    .dbg_state (st4)
  );

  // ---------------- counters / scoreboard ----------------
  int pass_cnt = 0;
  int total_cnt = 0;
  int overlap8 = 0;
  int done4_cnt = 0;
  logic [4:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one 8-bit operation and wait (bounded) for done.
  // lat counts sampled cycles from start assertion to done; bz counts busy.
  task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        output int lat, output int bz);
    a8 = av; b8 = bv; bin8 = cv; start8 = 1'b1;
    bz = 0;
    step();
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 40) begin
      if (busy8) bz++;
      step();
      lat++;
    end
  endtask

  // Scoreboard for the 4-bit sweep: compare each done against the oldest
  // expected {bout,diff}.
  always @(negedge clk) begin
    if (busy8 && done8) overlap8++;
    if (rst_n && done4) begin
      done4_cnt++;
      if (exp_q.size() == 0) begin
        check("w4_unexpected_done", 32'd1, 32'd0);
      end else begin
        check("w4_result", {27'd0, bout4, diff4}, {27'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int lat, bz, n, dn;
    logic [4:0] e5;

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    step(); step();

    // Reset state
    check("rst_busy", {31'd0, busy8}, 32'd0);
    check("rst_done", {31'd0, done8}, 32'd0);
    check("rst_diff", {24'd0, diff8}, 32'd0);
    check("rst_bout", {31'd0, bout8}, 32'd0);
    check("rst_state", {30'd0, st8}, {30'd0, ST_IDLE});
    rst_n = 1'b1;
    step();

    // 200 - 55 - 0 = 145
    do_op8(8'd200, 8'd55, 1'b0, lat, bz);
    check("t1_latency", lat, 32'd9);
    check("t1_busy_cycles", bz, 32'd8);
    check("t1_diff", {24'd0, diff8}, 32'h91);
    check("t1_bout", {31'd0, bout8}, 32'd0);
    step();
    check("t1_done_pulse", {31'd0, done8}, 32'd0);
    check("t1_idle", {30'd0, st8}, {30'd0, ST_IDLE});
    check("t1_hold_diff", {24'd0, diff8}, 32'h91);

    // Underflow and borrow-in cases
    do_op8(8'd5, 8'd10, 1'b0, lat, bz);
    check("t2_5m10_diff", {24'd0, diff8}, 32'hFB);
    check("t2_5m10_bout", {31'd0, bout8}, 32'd1);
    do_op8(8'd0, 8'd0, 1'b1, lat, bz);
    check("t2_0m0b_diff", {24'd0, diff8}, 32'hFF);
    check("t2_0m0b_bout", {31'd0, bout8}, 32'd1);
    do_op8(8'h80, 8'h7F, 1'b1, lat, bz);
    check("t2_80m7f_diff", {24'd0, diff8}, 32'h00);
    check("t2_80m7f_bout", {31'd0, bout8}, 32'd0);
    do_op8(8'h00, 8'hFF, 1'b0, lat, bz);
    check("t2_0mff_diff", {24'd0, diff8}, 32'h01);
    check("t2_0mff_bout", {31'd0, bout8}, 32'd1);
    do_op8(8'hFF, 8'hFF, 1'b1, lat, bz);
    check("t2_ffmff_diff", {24'd0, diff8}, 32'hFF);
    check("t2_ffmff_bout", {31'd0, bout8}, 32'd1);
    step();

    // start held high: back-to-back from DONE; input changes mid-RUN
    a8 = 8'd10; b8 = 8'd3; bin8 = 1'b0; start8 = 1'b1;
    step();
    n = 1;
    while (!done8 && n < 40) begin
      if (n == 3) begin a8 = 8'd100; b8 = 8'd1; end
      step();
      n++;
    end
    check("t3_first_latency", n, 32'd9);
    check("t3_first_diff", {24'd0, diff8}, 32'h07);
    check("t3_first_bout", {31'd0, bout8}, 32'd0);
    step();
    check("t3_b2b_busy", {31'd0, busy8}, 32'd1);
    check("t3_b2b_done", {31'd0, done8}, 32'd0);
    start8 = 1'b0; a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b1;
    n = 1;
    while (!done8 && n < 40) begin
      step();
      n++;
    end
    check("t3_second_latency", n, 32'd9);
    check("t3_second_diff", {24'd0, diff8}, 32'h63);
    check("t3_second_bout", {31'd0, bout8}, 32'd0);
    step();

    // Reset during RUN cycle 4 aborts with no done
    a8 = 8'd200; b8 = 8'd55; bin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    check("t4_rst_busy", {31'd0, busy8}, 32'd0);
    check("t4_rst_done", {31'd0, done8}, 32'd0);
    check("t4_rst_diff", {24'd0, diff8}, 32'd0);
    check("t4_rst_bout", {31'd0, bout8}, 32'd0);
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8) dn++;
      step();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (done8) dn++;
      step();
    end
    check("t4_no_done", dn, 32'd0);
    do_op8(8'd77, 8'd78, 1'b0, lat, bz);
    check("t4_after_latency", lat, 32'd9);
    check("t4_after_diff", {24'd0, diff8}, 32'hFF);
    check("t4_after_bout", {31'd0, bout8}, 32'd1);
    step();

    // start pulse during RUN is ignored: 60 - 15 - 1 = 44
    a8 = 8'h3C; b8 = 8'h0F; bin8 = 1'b1; start8 = 1'b1;
    step();
    start8 = 1'b0;
    dn = 0; bz = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy8) bz++;
      if (done8) dn++;
      start8 = (i == 3);
      step();
    end
    check("t6_done_count", dn, 32'd1);
    check("t6_busy_cycles", bz, 32'd8);
    check("t6_diff", {24'd0, diff8}, 32'h2C);
    check("t6_bout", {31'd0, bout8}, 32'd0);
    check("t6_idle", {30'd0, st8}, {30'd0, ST_IDLE});
    check("busy_done_overlap", overlap8, 32'd0);

    // 4-bit exhaustive sweep
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          a4 = 4'(ai); b4 = 4'(bi); bin4 = 1'(ci);
          e5 = {1'b0, a4} - {1'b0, b4} - {4'd0, bin4};
          exp_q.push_back(e5);
          start4 = 1'b1;
          step();
          start4 = 1'b0;
          n = 1;
          while (!done4 && n < 20) begin
            step();
            n++;
          end
          if (n >= 20) check("w4_timeout", n, 32'd5);
        end
      end
    end
    step(); step();
    check("w4_done_count", done4_cnt, 32'd512);
    check("w4_queue_empty", exp_q.size(), 32'd0);
    check("w4_idle", {30'd0, st4}, {30'd0, ST_IDLE});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
